// File: rtl/hls_dot_product_if.sv
// ---------------------------------------------------------------------------
// hls_dot_product_if
// Bundles the load/compute signals of the dot-product engine.
//   ram_init   : 1 = RAM load mode, 0 = compute enabled
//   n          : vector length, sampled when a computation starts
//   a_ram_in   : RAM A write data     a_addr_in : RAM A write address
//   b_ram_in   : RAM B write data     b_addr_in : RAM B write address
//   result     : dot product, valid while done_flag = 1
//   done_flag  : result valid, held until reset or ram_init
//   dbg_state  : engine FSM state (0 IDLE, 1 RUN, 2 FLUSH, 3 DONE)
// Handshake: there is no valid/ready pair. done_flag acts as a level-valid for
// result with no ready; the consumer may sample result on any cycle where
// done_flag = 1 and the value stays stable until reset or ram_init.
// ---------------------------------------------------------------------------
interface hls_dot_product_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              ram_init;
  logic [DATA_W-1:0] n;
  logic [DATA_W-1:0] a_ram_in;
  logic [DATA_W-1:0] b_ram_in;
  logic [ADDR_W-1:0] a_addr_in;
  logic [ADDR_W-1:0] b_addr_in;
  logic [DATA_W-1:0] result;
  logic              done_flag;
  logic [1:0]        dbg_state;

  modport master (
    output ram_init, n, a_ram_in, b_ram_in, a_addr_in, b_addr_in,
    input  result, done_flag, dbg_state
  );

  modport slave (
    input  ram_init, n, a_ram_in, b_ram_in, a_addr_in, b_addr_in,
    output result, done_flag, dbg_state
  );
endinterface

// File: rtl/hls_dot_product.sv
// ---------------------------------------------------------------------------
// hls_dot_product
// Two on-chip RAMs (A, B) are written while ram_init = 1; once ram_init and
// sys_rst are both low the engine computes result = sum(A[i]*B[i]),
// i = 0..n-1, unsigned and wrapping mod 2**DATA_W, then raises done_flag.
// Ports:
//   sys_clk : clock, rising edge
//   sys_rst : synchronous active-high reset (does not clear RAM contents)
//   bus     : hls_dot_product_if.slave (load inputs, result/done/debug)
// Pipeline: index -> synchronous RAM read -> registered product -> acc.
// done_flag first rises n+3 edges after the start edge (n = 0: 1 edge).
// ---------------------------------------------------------------------------
module hls_dot_product #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  hls_dot_product_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] n_r;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] result_r;
  logic              done_r;

  logic [DATA_W-1:0] mem_a [2**ADDR_W];
  logic [DATA_W-1:0] mem_b [2**ADDR_W];
  logic [DATA_W-1:0] a_dout;
  logic [DATA_W-1:0] b_dout;

  // rd_vld: a_dout/b_dout hold a requested element.
  // prod_vld: prod_r holds a product still to be accumulated.
  logic              rd_vld;
  logic [DATA_W-1:0] prod_r;
  logic              prod_vld;

  // RAM writes are independent of reset so loaded data survives it.
  // Read address is the low ADDR_W bits of the index, so n > depth wraps.
  always_ff @(posedge sys_clk) begin
    if (bus.ram_init) begin
      mem_a[bus.a_addr_in] <= bus.a_ram_in;
      mem_b[bus.b_addr_in] <= bus.b_ram_in;
    end
    a_dout <= mem_a[idx[ADDR_W-1:0]];
    b_dout <= mem_b[idx[ADDR_W-1:0]];
  end

  always_ff @(posedge sys_clk) begin
    // Product truncated to DATA_W bits; only consumed when prod_vld is set.
    prod_r <= a_dout * b_dout;
    if (sys_rst || bus.ram_init) begin
      state    <= IDLE;
      n_r      <= '0;
      idx      <= '0;
      acc      <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
      rd_vld   <= 1'b0;
      prod_vld <= 1'b0;
    end else begin
      rd_vld   <= (state == RUN);
      prod_vld <= rd_vld;
      if (prod_vld) begin
        acc <= acc + prod_r;
      end
      case (state)
        IDLE: begin
          n_r   <= bus.n;
          idx   <= '0;
          acc   <= '0;
          state <= (bus.n == '0) ? DONE : RUN;
        end
        RUN: begin
          idx <= idx + DATA_W'(1);
          if (idx == n_r - DATA_W'(1)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // With no read in flight, the add on this edge is the last one.
          if (!rd_vld) begin
            state <= DONE;
          end
        end
        DONE: begin
          result_r <= acc;
          done_r   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result    = result_r;
  assign bus.done_flag = done_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_hls_dot_product.sv
module tb_hls_dot_product;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  hls_dot_product_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  hls_dot_product #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b);
    bus.ram_init  = 1'b1;
    bus.a_addr_in = addr;
    bus.b_addr_in = addr;
    bus.a_ram_in  = a;
    bus.b_ram_in  = b;
    tick();
  endtask

  // Release ram_init/reset with length nv; the following edge is the start edge.
  task automatic start(input logic [DATA_W-1:0] nv);
    bus.ram_init = 1'b0;
    sys_rst      = 1'b0;
    bus.n        = nv;
    tick();
  endtask

  // Count edges after the start edge until done_flag is high (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.done_flag && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges;
    bus.ram_init  = 1'b0;
    bus.n         = '0;
    bus.a_ram_in  = '0;
    bus.b_ram_in  = '0;
    bus.a_addr_in = '0;
    bus.b_addr_in = '0;

    // Reset state
    tick();
    check("rst_done", 32'(bus.done_flag), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);

    // Load A[i]=B[i]=i while reset is held: writes still land
    for (int i = 0; i < 10; i++) load(ADDR_W'(i), DATA_W'(i), DATA_W'(i));
    bus.ram_init = 1'b0;
    tick();
    start(32'd10);
    wait_done(edges);
    check("sq10_done", 32'(bus.done_flag), 32'd1);
    check("sq10_latency", 32'(edges), 32'd13);
    check("sq10_result", bus.result, 32'd285);
    check("sq10_state", 32'(bus.dbg_state), 32'd3);
    tick();
    tick();
    check("sq10_hold_done", 32'(bus.done_flag), 32'd1);
    check("sq10_hold_result", bus.result, 32'd285);

    // Reset mid-run aborts; rerun from index 0 on retained RAM
    sys_rst = 1'b1;
    tick();
    start(32'd10);
    tick();
    tick();
    tick();
    check("midrun_done_low", 32'(bus.done_flag), 32'd0);
    sys_rst = 1'b1;
    tick();
    check("abort_done", 32'(bus.done_flag), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_state", 32'(bus.dbg_state), 32'd0);
    start(32'd10);
    wait_done(edges);
    check("rerun_latency", 32'(edges), 32'd13);
    check("rerun_result", bus.result, 32'd285);

    // ram_init during DONE clears outputs on the next edge
    load(16'd0, 32'd1, 32'd4);
    check("init_done_drop", 32'(bus.done_flag), 32'd0);
    check("init_result_drop", bus.result, 32'd0);
    load(16'd1, 32'd2, 32'd5);
    load(16'd2, 32'd3, 32'd6);
    start(32'd3);
    bus.n = 32'd7;  // must be ignored for this computation
    wait_done(edges);
    check("v3_latency", 32'(edges), 32'd6);
    check("v3_result", bus.result, 32'd32);

    // n = 0: done one edge after start, result 0
    load(16'd2, 32'd3, 32'd6);
    start(32'd0);
    check("n0_not_yet", 32'(bus.done_flag), 32'd0);
    wait_done(edges);
    check("n0_latency", 32'(edges), 32'd1);
    check("n0_result", bus.result, 32'd0);

    // Product wrap: 0x10000 * 0x10000 = 2**32 -> 0
    load(16'd0, 32'h0001_0000, 32'h0001_0000);
    start(32'd1);
    wait_done(edges);
    check("wrap0_latency", 32'(edges), 32'd4);
    check("wrap0_result", bus.result, 32'd0);

    // 0xFFFFFFFF squared mod 2**32 = 1
    load(16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start(32'd1);
    wait_done(edges);
    check("wrap1_done", 32'(bus.done_flag), 32'd1);
    check("wrap1_result", bus.result, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
